// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, hex-to-segment table and digit index type for seg7_scan
package seg7_pkg;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF = 4'hF;
  localparam logic [15:0][6:0] HEX_TAB = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  typedef logic [1:0] idx_t;
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational nibble to active-low g..a segment decoder
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = HEX_TAB[nib];
endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: 4-digit multiplexed 7-seg scanner with per-frame shadow load; SEG7_LZB_EN adds leading-zero blanking
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIV_W    = 32,
  parameter int SCAN_BIT = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div_cnt,
  input  logic [15:0]      value,
  input  logic [3:0]       dp,
  input  logic [3:0]       blank,
  output logic [3:0]       an,
  output logic [7:0]       seg,
  output logic             frame_sync
);
  logic        prev;
  idx_t        idx;
  logic [15:0] sh_val;
  logic [3:0]  sh_dp;
  logic [3:0]  sh_blank;
  logic [3:0]  ld_blank;
  logic [6:0]  dec;
  logic        tick;
  logic        blk;
  assign tick = div_cnt[SCAN_BIT] & ~prev;
  assign blk  = sh_blank[idx];
`ifdef SEG7_LZB_EN
  logic [3:0] lz;
  always_comb begin
    lz[3]    = (value[15:12] == 4'h0) && !dp[3];
    lz[2]    = lz[3] && (value[11:8] == 4'h0) && !dp[2];
    lz[1]    = lz[2] && (value[7:4] == 4'h0) && !dp[1];
    lz[0]    = 1'b0;
    ld_blank = blank | lz;
  end
`else
  assign ld_blank = blank;
`endif
  hex_to_seg7 u_dec (
    .nib(sh_val[{idx, 2'b00} +: 4]),
    .seg(dec)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      prev       <= 1'b0;
      idx        <= '0;
      sh_val     <= '0;
      sh_dp      <= '0;
      sh_blank   <= AN_OFF;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      frame_sync <= 1'b0;
    end else begin
      prev       <= div_cnt[SCAN_BIT];
      frame_sync <= tick && (idx == 2'd3);
      if (tick) idx <= idx + 1'b1;
      if (tick && (idx == 2'd3)) begin
        sh_val   <= value;
        sh_dp    <= dp;
        sh_blank <= ld_blank;
      end
      an  <= blk ? AN_OFF : ~(4'b0001 << idx);
      seg <= blk ? SEG_OFF : {~sh_dp[idx], dec};
    end
  end
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed self-checking bench for seg7_scan with SCAN_BIT=2
module tb_seg7_scan;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] div_cnt = '0;
  logic [15:0] value = '0;
  logic [3:0] dp = '0;
  logic [3:0] blank = '0;
  logic [3:0] an;
  logic [7:0] seg;
  logic       frame_sync;
  logic       cnt_en = 1'b0;
  int         total = 0;
  int         bad = 0;
  always #5 clk = ~clk;
  seg7_scan #(.DIV_W(8), .SCAN_BIT(2)) dut (
    .clk(clk), .rst(rst), .div_cnt(div_cnt), .value(value), .dp(dp),
    .blank(blank), .an(an), .seg(seg), .frame_sync(frame_sync)
  );
  task automatic cyc();
    @(negedge clk);
    if (cnt_en) div_cnt = div_cnt + 8'd1;
  endtask
  task automatic wait_sync(input string name, input logic dark);
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (frame_sync === 1'b1) return;
      if (dark) begin
        total++;
        if (an !== 4'hF || seg !== 8'hFF) begin
          bad++;
          $display("FAIL %s dark an=%h seg=%h exp an=f seg=ff", name, an, seg);
        end
      end
    end
    total++;
    bad++;
    $display("FAIL %s frame_sync timeout", name);
  endtask
  task automatic run_frame(input string name, input logic [3:0][3:0] ea, input logic [3:0][7:0] es,
                           input logic chg, input logic [15:0] nv);
    int fs_n;
    int p;
    int d;
    fs_n = (frame_sync === 1'b1) ? 1 : 0;
    for (int k = 1; k <= 31; k++) begin
      cyc();
      if (frame_sync === 1'b1) fs_n++;
      p = (k - 1) % 8;
      d = (k - 1) / 8;
      if (p == 0 || p == 6) begin
        total += 2;
        if (an !== ea[d]) begin
          bad++;
          $display("FAIL %s slot%0d k=%0d an=%h exp=%h", name, d, k, an, ea[d]);
        end
        if (seg !== es[d]) begin
          bad++;
          $display("FAIL %s slot%0d k=%0d seg=%h exp=%h", name, d, k, seg, es[d]);
        end
      end
      if (chg && k == 9) value = nv;
    end
    total++;
    if (fs_n != 1) begin
      bad++;
      $display("FAIL %s frame_sync pulses=%0d exp=1", name, fs_n);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    value = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      div_cnt = div_cnt + 8'd4;
      cyc();
      total++;
      if (an !== 4'hF || seg !== 8'hFF || frame_sync !== 1'b0) begin
        bad++;
        $display("FAIL reset an=%h seg=%h fs=%b exp f ff 0", an, seg, frame_sync);
      end
    end
    rst = 1'b0;
    div_cnt = '0;
    cnt_en = 1'b1;
    wait_sync("reset", 1'b1);
  endtask
  task automatic test_basic_tear();
    run_frame("basic", {4'h7, 4'hB, 4'hD, 4'hE}, {8'hF9, 8'hA4, 8'hB0, 8'h99}, 1'b1, 16'hABCD);
    wait_sync("tear", 1'b0);
    run_frame("tear", {4'h7, 4'hB, 4'hD, 4'hE}, {8'h88, 8'h83, 8'hC6, 8'hA1}, 1'b0, 16'h0);
  endtask
  task automatic test_edge();
    wait_sync("edge", 1'b0);
    cnt_en = 1'b0;
    div_cnt = 8'd0;
    for (int i = 0; i < 3; i++) cyc();
    total++;
    if (an !== 4'hE || seg !== 8'hA1) begin
      bad++;
      $display("FAIL edge idle an=%h seg=%h exp e a1", an, seg);
    end
    div_cnt = 8'd4;
    cyc();
    total++;
    if (an !== 4'hE) begin
      bad++;
      $display("FAIL edge lag an=%h exp=e", an);
    end
    for (int i = 2; i <= 20; i++) begin
      cyc();
      total++;
      if (an !== 4'hD || seg !== 8'hC6) begin
        bad++;
        $display("FAIL edge hold cyc%0d an=%h seg=%h exp d c6", i, an, seg);
      end
    end
    div_cnt = 8'd0;
    for (int i = 0; i < 3; i++) cyc();
    div_cnt = 8'd4;
    for (int i = 0; i < 3; i++) cyc();
    total++;
    if (an !== 4'hB || seg !== 8'h83) begin
      bad++;
      $display("FAIL edge second an=%h seg=%h exp b 83", an, seg);
    end
  endtask
  task automatic test_blank_dp();
    value = 16'h1234;
    blank = 4'b0100;
    dp = 4'b0001;
    div_cnt = 8'd0;
    cnt_en = 1'b1;
    wait_sync("blank_dp", 1'b0);
    run_frame("blank_dp", {4'h7, 4'hF, 4'hD, 4'hE}, {8'hF9, 8'hFF, 8'hB0, 8'h19}, 1'b0, 16'h0);
  endtask
  task automatic test_lzb();
    value = 16'h0007;
    blank = 4'b0000;
    dp = 4'b0000;
    wait_sync("lzb", 1'b0);
`ifdef SEG7_LZB_EN
    run_frame("lzb", {4'hF, 4'hF, 4'hF, 4'hE}, {8'hFF, 8'hFF, 8'hFF, 8'hF8}, 1'b0, 16'h0);
`else
    run_frame("lzb", {4'h7, 4'hB, 4'hD, 4'hE}, {8'hC0, 8'hC0, 8'hC0, 8'hF8}, 1'b0, 16'h0);
`endif
    dp = 4'b0100;
    wait_sync("lzb_dp", 1'b0);
`ifdef SEG7_LZB_EN
    run_frame("lzb_dp", {4'hF, 4'hB, 4'hD, 4'hE}, {8'hFF, 8'h40, 8'hC0, 8'hF8}, 1'b0, 16'h0);
`else
    run_frame("lzb_dp", {4'h7, 4'hB, 4'hD, 4'hE}, {8'hC0, 8'h40, 8'hC0, 8'hF8}, 1'b0, 16'h0);
`endif
  endtask
  initial begin
    test_reset();
    test_basic_tear();
    test_edge();
    test_blank_dp();
    test_lzb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
